truth_table_scanner: RTL and testbench



---
 rtl/tt_pkg.sv | 15 +
 rtl/truth_table_scanner_if.sv | 38 +++
 rtl/tt_settle_timer.sv | 36 +++
 rtl/truth_table_scanner.sv | 143 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table scanner harness.
// The scanner FSM states are shared with other harness stages.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } tt_state_e;

   localparam int unsigned TT_VECTORS = 16;
   localparam int unsigned TT_IDX_W   = 4;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Handshake and vector bus between a harness controller (master) and the scanner (slave).
// Optional compare signals exist only when TT_COMPARE_EN is defined.
interface truth_table_scanner_if;
   import tt_pkg::*;

   logic                    start;
   logic                    f_in;
   logic [TT_IDX_W-1:0]     abcd_out;
   logic                    busy;
   logic                    done;
   logic [TT_VECTORS-1:0]   table_out;
`ifdef TT_COMPARE_EN
   logic [TT_VECTORS-1:0]   expected;
   logic                    match;
   logic [4:0]              mismatch_cnt;
`endif

`ifdef TT_COMPARE_EN
   modport master (
      output start, f_in, expected,
      input  abcd_out, busy, done, table_out, match, mismatch_cnt
   );
   modport slave (
      input  start, f_in, expected,
      output abcd_out, busy, done, table_out, match, mismatch_cnt
   );
`else
   modport master (
      output start, f_in,
      input  abcd_out, busy, done, table_out
   );
   modport slave (
      input  start, f_in,
      output abcd_out, busy, done, table_out
   );
`endif

endinterface

// File: rtl/tt_settle_timer.sv
// Settle counter with synchronous load-to-zero, count enable and terminal-count flag.
module tt_settle_timer #(
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned TERMINAL = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps {a,b,c,d} over all 16 vectors, samples f_in after a settle time and builds a truth table.
// Optional feature macro: TT_COMPARE_EN (expected-table compare, match flag, mismatch count).
module truth_table_scanner
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned CNT_W         = 4
) (
   input logic                  clk,
   input logic                  reset,
   truth_table_scanner_if.slave tt
);

   localparam logic [TT_IDX_W-1:0] LAST_IDX = TT_IDX_W'(TT_VECTORS - 1);

   tt_state_e               state_q, state_d;
   logic [TT_IDX_W-1:0]     abcd_q, abcd_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [TT_VECTORS-1:0]   table_q, table_d;

   logic tmr_load, tmr_en, tmr_tc;
   logic accept, sample_en, finish;

   tt_settle_timer #(
      .CNT_W   (CNT_W),
      .TERMINAL(SETTLE_CYCLES - 1)
   ) u_settle_timer (
      .clk  (clk),
      .reset(reset),
      .load (tmr_load),
      .en   (tmr_en),
      .tc   (tmr_tc)
   );

   always_comb begin
      state_d   = state_q;
      abcd_d    = abcd_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      table_d   = table_q;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
      accept    = 1'b0;
      sample_en = 1'b0;
      finish    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (tt.start) begin
               accept   = 1'b1;
               state_d  = SETTLE;
               abcd_d   = '0;
               busy_d   = 1'b1;
               table_d  = '0;
               tmr_load = 1'b1;
            end
         end
         SETTLE: begin
            tmr_en = 1'b1;
            if (tmr_tc) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            sample_en       = 1'b1;
            table_d[abcd_q] = tt.f_in;
            tmr_load        = 1'b1;
            if (abcd_q == LAST_IDX) begin
               finish  = 1'b1;
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               abcd_d  = abcd_q + TT_IDX_W'(1);
               state_d = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         abcd_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         table_q <= '0;
      end else begin
         state_q <= state_d;
         abcd_q  <= abcd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         table_q <= table_d;
      end
   end

   assign tt.abcd_out  = abcd_q;
   assign tt.busy      = busy_q;
   assign tt.done      = done_q;
   assign tt.table_out = table_q;

`ifdef TT_COMPARE_EN
   logic [TT_VECTORS-1:0] exp_q, exp_d;
   logic [4:0]            mism_q, mism_d;
   logic                  match_q, match_d;

   // match is judged on the count including the final sample taken on the done edge
   always_comb begin
      exp_d   = exp_q;
      mism_d  = mism_q;
      match_d = match_q;
      if (accept) begin
         exp_d   = tt.expected;
         mism_d  = '0;
         match_d = 1'b0;
      end else begin
         if (sample_en && (tt.f_in != exp_q[abcd_q])) begin
            mism_d = mism_q + 5'd1;
         end
         if (finish) begin
            match_d = (mism_d == '0);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q   <= '0;
         mism_q  <= '0;
         match_q <= 1'b0;
      end else begin
         exp_q   <= exp_d;
         mism_q  <= mism_d;
         match_q <= match_d;
      end
   end

   assign tt.match        = match_q;
   assign tt.mismatch_cnt = mism_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: two scanners (SETTLE_CYCLES 1 and 3) against an arithmetic scan model.
module tb_truth_table_scanner;

   localparam int unsigned S0 = 1;
   localparam int unsigned S1 = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   truth_table_scanner_if tt0 ();
   truth_table_scanner_if tt1 ();

   truth_table_scanner #(.SETTLE_CYCLES(S0), .CNT_W(4)) dut0 (
      .clk(clk), .reset(reset), .tt(tt0.slave)
   );
   truth_table_scanner #(.SETTLE_CYCLES(S1), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .tt(tt1.slave)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   // function block under scan, one truth table per DUT
   logic [15:0] ftab [2];
   always_comb tt0.f_in = ftab[0][tt0.abcd_out];
   always_comb tt1.f_in = ftab[1][tt1.abcd_out];

   // ---------------- reference model ----------------
   int unsigned ncyc = 0;
   bit          act      [2];
   int unsigned cs       [2];
   logic [15:0] scan_tab [2];
   logic [15:0] scan_exp [2];

   function automatic int unsigned s_of(input int j);
      return (j == 0) ? S0 : S1;
   endfunction

   function automatic bit mdl_busy(input int j);
      int unsigned l;
      l = 16 * (s_of(j) + 1);
      return act[j] && ((ncyc - cs[j]) < l);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         act[0] = 1'b0;
         act[1] = 1'b0;
      end else begin
         logic st [2];
         logic [15:0] ex [2];
         st[0] = tt0.start;
         st[1] = tt1.start;
`ifdef TT_COMPARE_EN
         ex[0] = tt0.expected;
         ex[1] = tt1.expected;
`else
         ex[0] = '0;
         ex[1] = '0;
`endif
         ncyc++;
         for (int j = 0; j < 2; j++) begin
            if (st[j] && (!act[j] || (ncyc - cs[j]) > 16 * (s_of(j) + 1))) begin
               act[j]      = 1'b1;
               cs[j]       = ncyc;
               scan_tab[j] = ftab[j];
               scan_exp[j] = ex[j];
            end
         end
      end
   end

   function automatic void mdl_out(input int j, output logic [3:0] ab, output logic bz,
                                   output logic dn, output logic [15:0] tb,
                                   output logic [4:0] mm, output logic mt);
      int unsigned p, l, k, n;
      logic [15:0] mask;
      ab = '0; bz = 1'b0; dn = 1'b0; tb = '0; mm = '0; mt = 1'b0;
      p = s_of(j) + 1;
      l = 16 * p;
      if (act[j]) begin
         k = ncyc - cs[j];
         if (k < l) begin
            n    = k / p;
            mask = 16'((32'd1 << n) - 32'd1);
            bz   = 1'b1;
            ab   = 4'(n);
            tb   = scan_tab[j] & mask;
            mm   = 5'($countones((scan_tab[j] ^ scan_exp[j]) & mask));
         end else begin
            ab = 4'hF;
            dn = (k == l);
            tb = scan_tab[j];
            mm = 5'($countones(scan_tab[j] ^ scan_exp[j]));
            mt = (mm == 5'd0);
         end
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic cmp(input int j, input logic [3:0] ab, input logic bz, input logic dn,
                      input logic [15:0] tb, input logic [4:0] mm, input logic mt);
      logic [3:0] e_ab; logic e_bz, e_dn, e_mt; logic [15:0] e_tb; logic [4:0] e_mm;
      mdl_out(j, e_ab, e_bz, e_dn, e_tb, e_mm, e_mt);
      chk($sformatf("dut%0d abcd_out", j), 32'(ab), 32'(e_ab));
      chk($sformatf("dut%0d busy", j), 32'(bz), 32'(e_bz));
      chk($sformatf("dut%0d done", j), 32'(dn), 32'(e_dn));
      chk($sformatf("dut%0d table_out", j), 32'(tb), 32'(e_tb));
`ifdef TT_COMPARE_EN
      chk($sformatf("dut%0d mismatch_cnt", j), 32'(mm), 32'(e_mm));
      chk($sformatf("dut%0d match", j), 32'(mt), 32'(e_mt));
`endif
   endtask

   always @(negedge clk) begin
      if (!reset) begin
`ifdef TT_COMPARE_EN
         cmp(0, tt0.abcd_out, tt0.busy, tt0.done, tt0.table_out, tt0.mismatch_cnt, tt0.match);
         cmp(1, tt1.abcd_out, tt1.busy, tt1.done, tt1.table_out, tt1.mismatch_cnt, tt1.match);
`else
         cmp(0, tt0.abcd_out, tt0.busy, tt0.done, tt0.table_out, 5'd0, 1'b0);
         cmp(1, tt1.abcd_out, tt1.busy, tt1.done, tt1.table_out, 5'd0, 1'b0);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic mux_f(input logic [3:0] v);
      logic [7:0] ins;
      ins = {~v[0], 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      return ins[v[3:1]];
   endfunction

   task automatic pulse(input bit s0, input bit s1);
      @(negedge clk);
      tt0.start = s0;
      tt1.start = s1;
      @(negedge clk);
      tt0.start = 1'b0;
      tt1.start = 1'b0;
   endtask

   // called at the negedge right after the accept edge; counts cycles to each done pulse
   task automatic scan_wait(input int unsigned inj, output int unsigned c0, output int unsigned c1);
      c0 = 0;
      c1 = 0;
      for (int unsigned i = 1; i <= 200 && (c0 == 0 || c1 == 0); i++) begin
         @(negedge clk);
         if (c0 == 0 && tt0.done) c0 = i;
         if (c1 == 0 && tt1.done) c1 = i;
         tt0.start = (inj != 0 && i == inj - 1);
         tt1.start = (inj != 0 && i == inj - 1);
      end
      tt0.start = 1'b0;
      tt1.start = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      while ((tt0.busy || tt1.busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle wait", 32'(tt0.busy | tt1.busy), 32'd0);
   endtask

   logic [15:0] mux_tab, par_tab;
   int unsigned c0, c1, dseen;
   int unsigned dq[$];

   initial begin
      for (int v = 0; v < 16; v++) begin
         mux_tab[v] = mux_f(4'(v));
         par_tab[v] = ^(4'(v));
      end
      reset     = 1'b1;
      tt0.start = 1'b0;
      tt1.start = 1'b0;
      ftab[0]   = '0;
      ftab[1]   = '0;
`ifdef TT_COMPARE_EN
      tt0.expected = '0;
      tt1.expected = '0;
`endif
      repeat (3) @(negedge clk);
      chk("reset abcd_out", 32'(tt0.abcd_out), 32'd0);
      chk("reset busy", 32'(tt0.busy), 32'd0);
      chk("reset done", 32'(tt0.done), 32'd0);
      chk("reset table_out", 32'(tt0.table_out), 32'd0);
      reset = 1'b0;

      // mux function on S=1, parity on S=3
      ftab[0] = mux_tab;
      ftab[1] = par_tab;
      pulse(1'b1, 1'b1);
      chk("accept busy", 32'(tt0.busy), 32'd1);
      chk("accept abcd_out", 32'(tt0.abcd_out), 32'd0);
      scan_wait(0, c0, c1);
      chk("mux scan latency", c0, 32'd32);
      chk("parity scan latency", c1, 32'd64);
      chk("mux table", 32'(tt0.table_out), 32'h73F0);
      chk("parity table", 32'(tt1.table_out), 32'h6996);

      // start on cycle 5 of a scan is ignored
      pulse(1'b1, 1'b1);
      scan_wait(5, c0, c1);
      chk("midstart latency s1", c0, 32'd32);
      chk("midstart latency s3", c1, 32'd64);
      chk("midstart table", 32'(tt0.table_out), 32'h73F0);

      // async reset at cycle 10 aborts the scan
      pulse(1'b1, 1'b1);
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort abcd_out", 32'(tt0.abcd_out), 32'd0);
      chk("abort busy", 32'(tt0.busy), 32'd0);
      chk("abort table_out", 32'(tt0.table_out), 32'd0);
      chk("abort busy s3", 32'(tt1.busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      dseen = 0;
      repeat (40) begin
         @(negedge clk);
         if (tt0.done || tt1.done) dseen++;
      end
      chk("no done after abort", dseen, 32'd0);

      // start held high: back-to-back scans
      ftab[0] = 16'hFFFF;
      ftab[1] = 16'hFFFF;
      @(negedge clk);
      tt0.start = 1'b1;
      tt1.start = 1'b1;
      for (int unsigned i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (tt0.done) begin
            dq.push_back(i);
            chk("held table", 32'(tt0.table_out), 32'hFFFF);
         end
      end
      tt0.start = 1'b0;
      tt1.start = 1'b0;
      chk("held done count", dq.size(), 32'd3);
      if (dq.size() == 3) begin
         chk("held spacing 1", dq[1] - dq[0], 32'd33);
         chk("held spacing 2", dq[2] - dq[1], 32'd33);
      end
      wait_idle();

`ifdef TT_COMPARE_EN
      tt0.expected = 16'h73F0;
      ftab[0]      = 16'h73F0 ^ 16'h0080;
      pulse(1'b1, 1'b0);
      scan_wait(0, c0, c1);
      chk("forced latency", c0, 32'd32);
      chk("forced mismatch_cnt", 32'(tt0.mismatch_cnt), 32'd1);
      chk("forced match", 32'(tt0.match), 32'd0);
      ftab[0] = 16'h73F0;
      pulse(1'b1, 1'b0);
      scan_wait(0, c0, c1);
      chk("clean mismatch_cnt", 32'(tt0.mismatch_cnt), 32'd0);
      chk("clean match", 32'(tt0.match), 32'd1);
`endif

      // randomized starts, tables and occasional resets
      for (int unsigned r = 0; r < 3000; r++) begin
         @(negedge clk);
         if ($urandom_range(0, 599) == 0) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
         for (int j = 0; j < 2; j++) begin
            if (!mdl_busy(j) && $urandom_range(0, 3) == 0) begin
               ftab[j] = 16'($urandom);
`ifdef TT_COMPARE_EN
               if (j == 0) tt0.expected = $urandom_range(0, 1) ? ftab[0] : ftab[0] ^ 16'($urandom);
               else        tt1.expected = $urandom_range(0, 1) ? ftab[1] : ftab[1] ^ 16'($urandom);
`endif
            end
         end
         tt0.start = ($urandom_range(0, 5) == 0);
         tt1.start = ($urandom_range(0, 5) == 0);
      end
      tt0.start = 1'b0;
      tt1.start = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
